uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an input FIFO, the next generation of the team's fixed 8N1 transmitter. It accepts 5–9 data bits, optional odd/even parity and 1 or 2 stop bits. Words are queued in a small FIFO and sent back-to-back with no idle gap. It sits between the DFT result formatter and the board serial pin, so the producer can push bursts without polling per byte.

---
 rtl/uart_tx_fifo.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter with an input FIFO. 5-9 data bits, optional
//               odd/even parity, 1 or 2 stop bits. Queued words are sent
//               back-to-back with no idle gap between frames.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 12,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  localparam int c_addr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w  = $clog2(CLKS_PER_BIT);
  localparam int c_cw     = c_addr_w + 1;
  localparam logic [c_cnt_w-1:0] c_clk_last  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [3:0]         c_data_last = 4'(DATA_BITS - 1);
  localparam logic [3:0]         c_stop_last = 4'(STOP_BITS - 1);
  localparam logic [c_cw-1:0]    c_full      = c_cw'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [c_cnt_w-1:0]    clk_cnt_q, clk_cnt_d;
  logic [3:0]            bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  serial_q, serial_d;
  logic                  active_q, active_d;
  logic                  done_q, done_d;
  logic [DATA_BITS-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0]  fifo_mem_d [FIFO_DEPTH];
  logic [c_addr_w-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_addr_w-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0]       count_q, count_d;

  logic                  w_pop;
  logic                  w_wr_en;
  logic                  w_bit_end;
  logic [DATA_BITS-1:0]  w_head;

  assign w_head    = fifo_mem_q[rd_ptr_q];
  assign w_bit_end = (clk_cnt_q == '0);
  // A pop on the same edge frees a slot, so a write to a full FIFO is kept then.
  assign w_wr_en   = i_Tx_DV && ((count_q != c_full) || w_pop);

  // Serial framing FSM: bit timing, shifting, and FIFO pop requests.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;
    w_pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        if (count_q != '0) w_pop = 1'b1;
      end
      ST_START: begin
        if (w_bit_end) begin
          state_d   = ST_DATA;
          clk_cnt_d = c_clk_last;
          bit_idx_d = '0;
          serial_d  = shift_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q - c_cnt_w'(1);
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          clk_cnt_d = c_clk_last;
          if (bit_idx_q == c_data_last) begin
            bit_idx_d = '0;
            if (PARITY != 0) begin
              state_d  = ST_PARITY;
              serial_d = parity_q;
            end else begin
              state_d  = ST_STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            serial_d  = shift_q[1];
            shift_d   = shift_q >> 1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - c_cnt_w'(1);
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          state_d   = ST_STOP;
          clk_cnt_d = c_clk_last;
          bit_idx_d = '0;
          serial_d  = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q - c_cnt_w'(1);
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (bit_idx_q == c_stop_last) begin
            done_d = 1'b1;
            if (count_q != '0) begin
              w_pop = 1'b1;
            end else begin
              state_d   = ST_IDLE;
              active_d  = 1'b0;
              serial_d  = 1'b1;
              clk_cnt_d = '0;
              bit_idx_d = '0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            clk_cnt_d = c_clk_last;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - c_cnt_w'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        serial_d  = 1'b1;
        active_d  = 1'b0;
        clk_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase

    // Loading a word always starts a new start bit; parity is fixed at pop time.
    if (w_pop) begin
      shift_d   = w_head;
      parity_d  = (PARITY == 1) ? ~(^w_head) : (^w_head);
      state_d   = ST_START;
      clk_cnt_d = c_clk_last;
      bit_idx_d = '0;
      serial_d  = 1'b0;
      active_d  = 1'b1;
    end
  end

  // FIFO pointer, occupancy and storage update.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (w_wr_en) begin
      fifo_mem_d[wr_ptr_q] = i_Tx_Byte;
      wr_ptr_d             = wr_ptr_q + c_addr_w'(1);
    end
    if (w_pop) rd_ptr_d = rd_ptr_q + c_addr_w'(1);
    case ({w_wr_en, w_pop})
      2'b10:   count_d = count_q + c_cw'(1);
      2'b01:   count_d = count_q - c_cw'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers with synchronous reset; reset also flushes the FIFO.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage holds data only and needs no reset.
  always_ff @(posedge i_Clock) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign o_Tx_Ready   = (count_q != c_full);
  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Active  = active_q;
  assign o_Tx_Done    = done_q;
  assign o_Fifo_Count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo: framing for several
//               parameter sets, FIFO burst/overflow, mid-frame reset and
//               write-on-pop while full.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] tx_dv;
  logic [7:0] tx_byte;
  wire  [3:0] rdy, ser, act, done;
  wire  [3:0][2:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // 8N1
  uart_tx_fifo #(.CLKS_PER_BIT(12), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(tx_dv[0]), .i_Tx_Byte(tx_byte),
    .o_Tx_Ready(rdy[0]), .o_Tx_Serial(ser[0]), .o_Tx_Active(act[0]), .o_Tx_Done(done[0]),
    .o_Fifo_Count(cnt[0]));
  // 8E1
  uart_tx_fifo #(.CLKS_PER_BIT(12), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(tx_dv[1]), .i_Tx_Byte(tx_byte),
    .o_Tx_Ready(rdy[1]), .o_Tx_Serial(ser[1]), .o_Tx_Active(act[1]), .o_Tx_Done(done[1]),
    .o_Fifo_Count(cnt[1]));
  // 8O1
  uart_tx_fifo #(.CLKS_PER_BIT(12), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(tx_dv[2]), .i_Tx_Byte(tx_byte),
    .o_Tx_Ready(rdy[2]), .o_Tx_Serial(ser[2]), .o_Tx_Active(act[2]), .o_Tx_Done(done[2]),
    .o_Fifo_Count(cnt[2]));
  // 7N2
  uart_tx_fifo #(.CLKS_PER_BIT(12), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut3 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(tx_dv[3]), .i_Tx_Byte(tx_byte[6:0]),
    .o_Tx_Ready(rdy[3]), .o_Tx_Serial(ser[3]), .o_Tx_Active(act[3]), .o_Tx_Done(done[3]),
    .o_Fifo_Count(cnt[3]));

  typedef struct {
    int         d;      // which instance
    logic [7:0] data;
    int         nb;     // bits per frame
    logic [11:0] fr;    // expected line bits, bit k is the k-th bit sent
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One word into instance d, then the whole frame checked cycle by cycle.
  task automatic run_vec(input int d, input logic [7:0] data, input int nb, input logic [11:0] fr);
    int bad;
    @(negedge clk); tx_dv[d] = 1'b1; tx_byte = data;
    @(negedge clk); tx_dv[d] = 1'b0;
    check($sformatf("d%0d_lat_count", d), 32'(cnt[d]), 1);
    check($sformatf("d%0d_lat_idle", d), 32'(ser[d]), 1);
    @(negedge clk);
    check($sformatf("d%0d_pop_count", d), 32'(cnt[d]), 0);
    for (int k = 0; k < nb; k++) begin
      bad = 0;
      for (int c = 0; c < 12; c++) begin
        if (ser[d] !== fr[k] || act[d] !== 1'b1 || done[d] !== 1'b0) bad++;
        @(negedge clk);
      end
      check($sformatf("d%0d_%02h_bit%0d_bad_cycles", d, data, k), 32'(bad), 0);
    end
    check($sformatf("d%0d_done_pulse", d), 32'(done[d]), 1);
    check($sformatf("d%0d_active_fall", d), 32'(act[d]), 0);
    check($sformatf("d%0d_line_idle", d), 32'(ser[d]), 1);
    @(negedge clk);
    check($sformatf("d%0d_done_single", d), 32'(done[d]), 0);
  endtask

  // Words 0x11,0x22,... on consecutive cycles into dut0. late=0: sixth word
  // hits a full FIFO and is dropped. late=1: sixth word is written on the
  // exact edge that pops word 2 while full.
  task automatic burst(input bit late);
    int nf, bad, dones, f;
    logic [7:0] w;
    logic [9:0] fr;
    nf = late ? 6 : 5;
    @(negedge clk); tx_dv[0] = 1'b1; tx_byte = 8'h11;
    @(negedge clk); tx_byte = 8'h22;
    check("burst_cnt_first", 32'(cnt[0]), 1);
    @(negedge clk);
    bad = 0; dones = 0;
    for (int t = 0; t <= nf * 120; t++) begin
      if (t == 3) check($sformatf("burst%0d_full_ready", late), 32'(rdy[0]), 0);
      if (t == 4) check($sformatf("burst%0d_full_count", late), 32'(cnt[0]), 4);
      if (t == 119 && late) check("late_ready_before_pop", 32'(rdy[0]), 0);
      if (t == 120) check($sformatf("burst%0d_count_after_pop", late), 32'(cnt[0]), late ? 4 : 3);
      if (t < 3) begin
        tx_dv[0] = 1'b1; tx_byte = 8'(8'h11 * (t + 3));
      end else if ((t == 3 && !late) || (t == 119 && late)) begin
        tx_dv[0] = 1'b1; tx_byte = 8'h66;
      end else begin
        tx_dv[0] = 1'b0;
      end
      if (t < nf * 120) begin
        f  = t / 120;
        w  = 8'(8'h11 * (f + 1));
        fr = {1'b1, w, 1'b0};
        if (ser[0] !== fr[(t % 120) / 12] || act[0] !== 1'b1) bad++;
      end else begin
        check($sformatf("burst%0d_end_active", late), 32'(act[0]), 0);
        check($sformatf("burst%0d_end_line", late), 32'(ser[0]), 1);
      end
      if (done[0] === 1'b1) begin
        dones++;
        if (t % 120 != 0 || t == 0) bad++;
      end
      @(negedge clk);
    end
    check($sformatf("burst%0d_line_bad_cycles", late), 32'(bad), 0);
    check($sformatf("burst%0d_done_count", late), 32'(dones), 32'(nf));
  endtask

  // Reset for one cycle during the data bits of frame 2 of 3.
  task automatic mid_reset();
    int bad;
    @(negedge clk); tx_dv[0] = 1'b1; tx_byte = 8'h81;
    @(negedge clk); tx_byte = 8'h42;
    @(negedge clk); tx_byte = 8'h24;
    @(negedge clk); tx_dv[0] = 1'b0;
    repeat (149) @(negedge clk);
    check("rst_pre_active", 32'(act[0]), 1);
    check("rst_pre_count", 32'(cnt[0]), 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst_line", 32'(ser[0]), 1);
    check("rst_count", 32'(cnt[0]), 0);
    check("rst_active", 32'(act[0]), 0);
    check("rst_done", 32'(done[0]), 0);
    check("rst_ready", 32'(rdy[0]), 1);
    bad = 0;
    for (int t = 0; t < 300; t++) begin
      if (ser[0] !== 1'b1 || act[0] !== 1'b0 || done[0] !== 1'b0) bad++;
      @(negedge clk);
    end
    check("rst_quiet_bad_cycles", 32'(bad), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; tx_dv = '0; tx_byte = '0;
    repeat (3) @(negedge clk);
    check("reset_line", 32'(ser), 32'hF);
    check("reset_active", 32'(act), 0);
    check("reset_done", 32'(done), 0);
    check("reset_ready", 32'(rdy), 32'hF);
    check("reset_count", 32'(cnt[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_line", 32'(ser[0]), 1);

    vecs[0] = '{0, 8'hA5, 10, 12'({1'b1, 8'hA5, 1'b0})};
    vecs[1] = '{0, 8'h3C, 10, 12'({1'b1, 8'h3C, 1'b0})};
    vecs[2] = '{1, 8'h55, 11, 12'({1'b1, 1'b0, 8'h55, 1'b0})};  // even, 4 ones
    vecs[3] = '{2, 8'h55, 11, 12'({1'b1, 1'b1, 8'h55, 1'b0})};  // odd, 4 ones
    vecs[4] = '{1, 8'h01, 11, 12'({1'b1, 1'b1, 8'h01, 1'b0})};  // even, 1 one
    vecs[5] = '{2, 8'h03, 11, 12'({1'b1, 1'b1, 8'h03, 1'b0})};  // odd, 2 ones
    vecs[6] = '{3, 8'h7F, 10, 12'({2'b11, 7'h7F, 1'b0})};
    vecs[7] = '{3, 8'h2A, 10, 12'({2'b11, 7'h2A, 1'b0})};

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i].d, vecs[i].data, vecs[i].nb, vecs[i].fr);
    end

    burst(1'b0);
    repeat (5) @(negedge clk);
    burst(1'b1);
    repeat (5) @(negedge clk);
    mid_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
